tt_sweep_checker: RTL

- Sequential counterpart to the team's combinational boolean-expression blocks.
- Generates every input combination for an N_IN-input function and drives it to two implementations of that function: the unsimplified reference and the simplified DUT.
- Samples both outputs for each combination, captures both truth tables and reports any mismatch.
- Replaces hand-written exhaustive stimulus with a reusable self-checking engine that can sit in a bench or on silicon.

---
 rtl/tt_sweep_if.sv | 28 ++
 rtl/tt_sweep_checker.sv | 81 ++++++++
 2 files changed

// File: rtl/tt_sweep_if.sv
// tt_sweep_if: sweep-checker bus.
// master (checker): takes start, s_ref, s_dut; drives vec_out, busy, done,
//   equal, tt_ref, tt_dut, mismatch_mask, first_fail, fail_count.
// slave (user): the mirror image.
interface tt_sweep_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic                 s_ref;
    logic                 s_dut;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 equal;
    logic [2**N_IN-1:0]   tt_ref;
    logic [2**N_IN-1:0]   tt_dut;
    logic [2**N_IN-1:0]   mismatch_mask;
    logic [N_IN-1:0]      first_fail;
    logic [N_IN:0]        fail_count;
    modport master (
        input  start, s_ref, s_dut,
        output vec_out, busy, done, equal, tt_ref, tt_dut, mismatch_mask, first_fail, fail_count
    );
    modport slave (
        output start, s_ref, s_dut,
        input  vec_out, busy, done, equal, tt_ref, tt_dut, mismatch_mask, first_fail, fail_count
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive truth-table sweep comparing a reference and a simplified function.
// Ports: clk, rst (sync, active high); bus (tt_sweep_if.master) carries start,
//   s_ref/s_dut in, and vec_out, busy, done, equal, tt_ref, tt_dut,
//   mismatch_mask, first_fail, fail_count out. SETTLE must be >= 1.
module tt_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic        clk,
    input logic        rst,
    tt_sweep_if.master bus
);
    localparam int              NV       = 2 ** N_IN;
    localparam int              CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          miss;

    assign miss     = bus.s_ref ^ bus.s_dut;
    assign bus.busy = (state == DRIVE) || (state == SAMPLE);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = (state == IDLE)   ? (bus.start ? DRIVE : IDLE) :
                  (state == DRIVE)  ? ((cnt == CNT_LAST) ? SAMPLE : DRIVE) :
                  (state == SAMPLE) ? ((bus.vec_out == VEC_LAST) ? DONE : DRIVE) :
                                      IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vec_out       <= '0;
            cnt               <= '0;
            bus.tt_ref        <= '0;
            bus.tt_dut        <= '0;
            bus.mismatch_mask <= '0;
            bus.first_fail    <= '0;
            bus.fail_count    <= '0;
            bus.equal         <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            bus.vec_out       <= '0;
            cnt               <= '0;
            bus.tt_ref        <= '0;
            bus.tt_dut        <= '0;
            bus.mismatch_mask <= '0;
            bus.first_fail    <= '0;
            bus.fail_count    <= '0;
            bus.equal         <= 1'b0;
        end else if (state == DRIVE) begin
            cnt <= cnt + 1'b1;
        end else if (state == SAMPLE) begin
            bus.tt_ref[bus.vec_out] <= bus.s_ref;
            bus.tt_dut[bus.vec_out] <= bus.s_dut;
            if (miss) begin
                bus.mismatch_mask[bus.vec_out] <= 1'b1;
                bus.fail_count                 <= bus.fail_count + 1'b1;
                if (bus.fail_count == '0) bus.first_fail <= bus.vec_out;
            end
            // equal is settled on the last sample so it is already valid during DONE
            if (bus.vec_out == VEC_LAST) begin
                bus.equal <= (bus.fail_count == '0) && !miss;
            end else begin
                bus.vec_out <= bus.vec_out + 1'b1;
                cnt         <= '0;
            end
        end else if (state == DONE) begin
            bus.equal <= (bus.fail_count == '0);
        end
    end
endmodule
